// File: rtl/inout_mem_pkg.sv
// inout_mem_pkg: shared state encoding and constants
// for the bidirectional-bus memory controller.
package inout_mem_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    TURN
  } state_t;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  // Counter holds at most RD_LAT-2; keep at least one bit.
  function automatic int lat_cnt_w(input int rd_lat);
    return (rd_lat <= 3) ? 1 : $clog2(rd_lat - 1);
  endfunction

endpackage

// File: rtl/inout_mem_array.sv
// inout_mem_array: DEPTH x DATA_W storage with one
// synchronous write port and a registered read port.
module inout_mem_array #(
  parameter int DATA_W = 18,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              oob,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Out-of-range reads return all-ones instead of array contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= oob ? '1 : mem[raddr];
    end
  end

endmodule

// File: rtl/inout_mem_ctrl.sv
// inout_mem_ctrl: single-port memory on a shared tri-state bus
// with clear sweep, read latency, turnaround and range check.
module inout_mem_ctrl
  import inout_mem_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] address,
  input  logic              MEM_RW,
  input  logic              MEM_OE,
  inout  wire  [DATA_W-1:0] MEM_DATA_bidir,
  output logic              rd_valid,
  output logic              err,
  output logic              init_done
);

  localparam int CW = lat_cnt_w(RD_LAT);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CW-1:0] LAT_LD =
    CW'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [CW-1:0]     lat_cnt;
  logic              accept;
  logic              oob;
  logic              re;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rd_data;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign oob       = ({1'b0, address} >= DEPTH_V);
  assign re        = accept && (MEM_RW == MEM_RD);

  // INIT owns the write port; otherwise only in-range writes land.
  always_comb begin
    we    = 1'b0;
    waddr = address;
    wdata = MEM_DATA_bidir;
    unique case (1'b1)
      state == INIT: begin
        we    = 1'b1;
        waddr = clr_cnt;
        wdata = '0;
      end
      accept && MEM_RW == MEM_WR && !oob: begin
        we = 1'b1;
      end
      default: ;
    endcase
  end

  inout_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (address),
    .oob   (oob),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      clr_cnt   <= '0;
      lat_cnt   <= '0;
      rd_valid  <= 1'b0;
      err       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      err      <= accept && oob;
      rd_valid <= 1'b0;
      unique case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST) begin
            clr_cnt   <= '0;
            state     <= IDLE;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (re) begin
            if (RD_LAT == 1) begin
              state    <= RD_DRIVE;
              rd_valid <= 1'b1;
            end else begin
              state   <= RD_WAIT;
              lat_cnt <= LAT_LD;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt == '0) begin
            state    <= RD_DRIVE;
            rd_valid <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RD_DRIVE: state <= TURN;
        TURN:     state <= IDLE;
        default:  state <= INIT;
      endcase
    end
  end

  // rd_valid is reset asynchronously, so the bus frees with rst_n.
  assign MEM_DATA_bidir = (rd_valid && MEM_OE) ? rd_data : 'z;

endmodule

// File: tb/tb_inout_mem_ctrl.sv
// tb_inout_mem_ctrl: two controller configurations driven with
// directed and random traffic against a word-level memory model.
module tb_inout_mem_ctrl;

  localparam int DW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          rv   [2];
  logic          rw   [2];
  logic          oe   [2];
  logic          men  [2];
  logic [2:0]    addr [2];
  logic [DW-1:0] wdat [2];
  logic          rdy  [2];
  logic          rdv  [2];
  logic          err  [2];
  logic          idn  [2];
  wire  [DW-1:0] bus0;
  wire  [DW-1:0] bus1;

  assign bus0 = men[0] ? wdat[0] : 'z;
  assign bus1 = men[1] ? wdat[1] : 'z;

  inout_mem_ctrl #(.DATA_W(DW), .DEPTH(4), .RD_LAT(1)) u0 (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (rv[0]),
    .req_ready      (rdy[0]),
    .address        (addr[0][1:0]),
    .MEM_RW         (rw[0]),
    .MEM_OE         (oe[0]),
    .MEM_DATA_bidir (bus0),
    .rd_valid       (rdv[0]),
    .err            (err[0]),
    .init_done      (idn[0])
  );

  inout_mem_ctrl #(.DATA_W(DW), .DEPTH(5), .RD_LAT(3)) u1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (rv[1]),
    .req_ready      (rdy[1]),
    .address        (addr[1]),
    .MEM_RW         (rw[1]),
    .MEM_OE         (oe[1]),
    .MEM_DATA_bidir (bus1),
    .rd_valid       (rdv[1]),
    .err            (err[1]),
    .init_done      (idn[1])
  );

  int            depth [2];
  int            lat   [2];
  logic [DW-1:0] model [2][8];
  logic [DW-1:0] zz;
  int            n_chk;
  int            n_fail;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  function automatic logic [DW-1:0] bus_of(int i);
    return (i != 0) ? bus1 : bus0;
  endfunction

  task automatic wait_rdy(int i);
    int n = 0;
    while (!rdy[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[i]) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(int i, logic w, logic [2:0] a, logic [DW-1:0] d);
    wait_rdy(i);
    rv[i]   = 1'b1;
    rw[i]   = w;
    addr[i] = a;
    wdat[i] = d;
    men[i]  = w;
    @(posedge clk);
    #1;
    rv[i]  = 1'b0;
    men[i] = 1'b0;
    if (w && a < depth[i]) model[i][a] = d;
    @(negedge clk);
    chk("err", err[i], 32'(a >= depth[i]));
    if (w) chk("wr_ready", rdy[i], 1);
  endtask

  task automatic rd(int i, logic [2:0] a, logic o);
    logic [DW-1:0] want;
    want  = (a < depth[i]) ? model[i][a] : '1;
    oe[i] = o;
    issue(i, 1'b0, a, '0);
    for (int k = 1; k < lat[i]; k++) begin
      chk("wait_valid", rdv[i], 0);
      chk("wait_bus", bus_of(i), zz);
      chk("wait_ready", rdy[i], 0);
      @(negedge clk);
    end
    chk("rd_valid", rdv[i], 1);
    chk("rd_data", bus_of(i), o ? want : zz);
    @(negedge clk);
    chk("turn_valid", rdv[i], 0);
    chk("turn_bus", bus_of(i), zz);
    chk("turn_ready", rdy[i], 0);
    @(negedge clk);
    chk("idle_ready", rdy[i], 1);
    oe[i] = 1'b1;
  endtask

  task automatic do_reset();
    int first [2];
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rv[i]  = 1'b0;
      men[i] = 1'b0;
      for (int a = 0; a < 8; a++) model[i][a] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", rdy[i], 0);
      chk("rst_valid", rdv[i], 0);
      chk("rst_err", err[i], 0);
      chk("rst_init_done", idn[i], 0);
      chk("rst_bus", bus_of(i), zz);
    end
    rst_n    = 1'b1;
    first[0] = -1;
    first[1] = -1;
    for (int n = 0; n <= 12; n++) begin
      for (int i = 0; i < 2; i++)
        if (first[i] < 0 && rdy[i]) first[i] = n;
      if (first[0] >= 0 && first[1] >= 0) break;
      @(negedge clk);
    end
    chk("init_cycles0", first[0], 32'd4);
    chk("init_cycles1", first[1], 32'd5);
    chk("init_done0", idn[0], 1);
    chk("init_done1", idn[1], 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            i;
    logic          w;
    logic [2:0]    a;
    logic [DW-1:0] d;
    logic          o;
    zz       = 'z;
    depth[0] = 4;
    depth[1] = 5;
    lat[0]   = 1;
    lat[1]   = 3;
    n_chk    = 0;
    n_fail   = 0;
    for (int k = 0; k < 2; k++) begin
      rv[k]   = 1'b0;
      rw[k]   = 1'b0;
      oe[k]   = 1'b1;
      men[k]  = 1'b0;
      addr[k] = '0;
      wdat[k] = '0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    for (int k = 0; k < 2; k++)
      for (int x = 0; x < depth[k]; x++) rd(k, 3'(x), 1'b1);

    issue(0, 1'b1, 3'd2, 18'h2A5A5);
    rd(0, 3'd2, 1'b1);
    issue(1, 1'b1, 3'd1, 18'h00123);
    rd(1, 3'd1, 1'b1);
    rd(1, 3'd1, 1'b0);
    rd(1, 3'd1, 1'b1);
    rd(0, 3'd2, 1'b0);
    rd(0, 3'd2, 1'b1);

    issue(1, 1'b1, 3'd6, 18'h15555);
    for (int x = 0; x < 5; x++) rd(1, 3'(x), 1'b1);
    rd(1, 3'd7, 1'b1);

    for (int x = 0; x < 4; x++) issue(0, 1'b1, 3'(x), DW'($urandom));
    for (int x = 0; x < 4; x++) rd(0, 3'(x), 1'b1);

    repeat (150) begin
      i = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = (i != 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      d = DW'($urandom);
      o = ($urandom_range(0, 3) != 0);
      if (w) issue(i, 1'b1, a, d);
      else   rd(i, a, o);
    end

    issue(1, 1'b1, 3'd1, 18'h0BEEF);
    oe[1] = 1'b1;
    issue(1, 1'b0, 3'd1, '0);
    chk("rdwait_valid", rdv[1], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rdwait_bus", bus1, zz);
    chk("rst_rdwait_valid", rdv[1], 0);
    do_reset();
    rd(1, 3'd1, 1'b1);

    issue(0, 1'b1, 3'd3, 18'h1C3C3);
    oe[0] = 1'b1;
    issue(0, 1'b0, 3'd3, '0);
    chk("drive_bus", bus0, 18'h1C3C3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_drive_bus", bus0, zz);
    chk("rst_drive_valid", rdv[0], 0);
    do_reset();
    rd(0, 3'd3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
